// File: rtl/ex_div_if.sv
// EX-stage <-> divide sequencer handshake and result bus.
// The EX stage owns the master side; the divider owns the slave side.
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             cancel;
    logic             stall;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_op, operand_a, operand_b, cancel,
        input  stall, ready, quotient, remainder
    );

    modport slave (
        input  start, signed_op, operand_a, operand_b, cancel,
        output stall, ready, quotient, remainder
    );
endinterface

// File: rtl/ex_div_sequencer.sv
// Multi-cycle restoring divider for the EX stage (DIV / DIVU).
// One shift-subtract step per cycle on operand magnitudes, sign fixup
// applied when the result is committed on entry to DONE. A zero divisor
// takes a one-cycle side path yielding all-ones / unmodified dividend.
module ex_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic    clock,
    input  logic    reset,
    ex_div_if.slave div
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        BUSY     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   count_r;
    logic               signed_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [WIDTH-1:0]   quo_r;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   rem_r;       // partial remainder
    logic               ready_r;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;

    logic               accept_s;
    logic               last_s;
    logic               stall_s;
    logic               neg_q_s;
    logic               neg_r_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [WIDTH-1:0]   rem_next_s;

    // Two's complement negate when en is set; wrap-around is intentional.
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic             en);
        logic [WIDTH-1:0] res;
        if (en) begin
            res = {WIDTH{1'b0}} - v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    assign accept_s = div.start & ~div.cancel;
    assign last_s   = (count_r == CNT_LAST);
    assign neg_q_s  = signed_r & (sign_a_r ^ sign_b_r);
    assign neg_r_s  = signed_r & sign_a_r;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        shifted_s  = {rem_r, quo_r[WIDTH-1]};
        diff_s     = shifted_s - {1'b0, divisor_r};
        quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        rem_next_s = shifted_s[WIDTH-1:0];
        if (!diff_s[WIDTH]) begin
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
            rem_next_s = diff_s[WIDTH-1:0];
        end else begin
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
            rem_next_s = shifted_s[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; cancel aborts both working states.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (div.operand_b == {WIDTH{1'b0}}) begin
                        state_next_s = DIV_ZERO;
                    end else begin
                        state_next_s = BUSY;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (div.cancel) begin
                    state_next_s = IDLE;
                end else if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DIV_ZERO: begin
                if (div.cancel) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output: stall freezes the front of the pipe while a divide is live.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:     stall_s = accept_s;
            BUSY:     stall_s = 1'b1;
            DIV_ZERO: stall_s = 1'b1;
            DONE:     stall_s = 1'b0;
            default:  stall_s = 1'b0;
        endcase
    end

    // Operand capture, iteration datapath and result commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r     <= {CNT_W{1'b0}};
            signed_r    <= 1'b0;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            divisor_r   <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            ready_r     <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        signed_r  <= div.signed_op;
                        sign_a_r  <= div.operand_a[WIDTH-1];
                        sign_b_r  <= div.operand_b[WIDTH-1];
                        divisor_r <= cond_negate(div.operand_b,
                                                 div.signed_op & div.operand_b[WIDTH-1]);
                        rem_r     <= {WIDTH{1'b0}};
                        count_r   <= {CNT_W{1'b0}};
                        // A zero divisor returns the raw dividend, so keep it unmodified.
                        if (div.operand_b == {WIDTH{1'b0}}) begin
                            quo_r <= div.operand_a;
                        end else begin
                            quo_r <= cond_negate(div.operand_a,
                                                 div.signed_op & div.operand_a[WIDTH-1]);
                        end
                    end
                end
                BUSY: begin
                    if (!div.cancel) begin
                        quo_r   <= quo_next_s;
                        rem_r   <= rem_next_s;
                        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (last_s) begin
                            quotient_r  <= cond_negate(quo_next_s, neg_q_s);
                            remainder_r <= cond_negate(rem_next_s, neg_r_s);
                        end
                    end
                end
                DIV_ZERO: begin
                    if (!div.cancel) begin
                        quotient_r  <= {WIDTH{1'b1}};
                        remainder_r <= quo_r;
                    end
                end
                DONE: begin
                    count_r <= {CNT_W{1'b0}};
                end
                default: begin
                    count_r <= {CNT_W{1'b0}};
                end
            endcase
            ready_r <= (state_next_s == DONE);
        end
    end

    assign div.stall     = stall_s;
    assign div.ready     = ready_r;
    assign div.quotient  = quotient_r;
    assign div.remainder = remainder_r;
endmodule

// File: tb/tb_ex_div_sequencer.sv
// Directed bench for ex_div_sequencer: stimulus pushes expected results
// into a scoreboard, a negedge monitor pops and compares on each ready.
module tb_ex_div_sequencer;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           due;
    } exp_t;

    exp_t sb[$];

    ex_div_if #(.WIDTH(W)) dif ();

    ex_div_sequencer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .div   (dif.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset && dif.ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: got ready=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", dif.quotient, e.q);
                chk("remainder", dif.remainder, e.r);
                chk("latency", W'(cyc), W'(e.due));
            end
        end
    end

    // Issue one divide, scramble operands afterwards, count stall cycles until ready.
    task automatic run_div(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r,
                           input int lat, input logic hold_start);
        exp_t e;
        int   stall_cnt;
        bit   done;
        @(posedge clock); #1;
        dif.start     = 1'b1;
        dif.cancel    = 1'b0;
        dif.signed_op = sop;
        dif.operand_a = a;
        dif.operand_b = b;
        e.q = q; e.r = r; e.due = cyc + lat;
        sb.push_back(e);
        stall_cnt = 0;
        done = 1'b0;
        for (int i = 0; i <= lat + 5 && !done; i++) begin
            @(negedge clock);
            if (dif.stall === 1'b1) stall_cnt++;
            if (dif.ready === 1'b1) done = 1'b1;
            @(posedge clock); #1;
            if (!hold_start || done) dif.start = 1'b0;
            dif.operand_a = $urandom;
            dif.operand_b = $urandom;
            dif.signed_op = ~sop;
        end
        dif.start = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no ready expected ready within %0d cycles", lat + 5);
        end else begin
            chk("stall_cycles", W'(stall_cnt), W'(lat));
        end
    endtask

    initial begin
        int c0;
        dif.start = 1'b0; dif.cancel = 1'b0; dif.signed_op = 1'b0;
        dif.operand_a = '0; dif.operand_b = '0;

        // Reset state
        #3;
        chk("rst_ready", W'(dif.ready), 32'd0);
        chk("rst_quotient", dif.quotient, 32'd0);
        chk("rst_remainder", dif.remainder, 32'd0);
        chk("rst_stall", W'(dif.stall), 32'd0);
        #4 reset = 1'b1;

        // Main function and boundaries
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b0);
        run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2, 1'b0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 2, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33, 1'b0);
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
        run_div(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 33, 1'b0);
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);
        run_div(1'b0, 32'h1234_5678, 32'h0000_1000, 32'h0001_2345, 32'h0000_0678, 33, 1'b0);

        // Cancel in BUSY at cycle 10: back to IDLE, results held
        @(posedge clock); #1;
        dif.start = 1'b1; dif.signed_op = 1'b0; dif.operand_a = 32'd100; dif.operand_b = 32'd7;
        c0 = cyc;
        @(posedge clock); #1;
        dif.start = 1'b0;
        while (cyc < c0 + 10) @(posedge clock);
        #1 dif.cancel = 1'b1;
        @(negedge clock);
        chk("stall_busy", W'(dif.stall), 32'd1);
        @(posedge clock); #1;
        dif.cancel = 1'b0;
        @(negedge clock);
        chk("stall_after_cancel", W'(dif.stall), 32'd0);
        chk("held_quotient", dif.quotient, 32'h0001_2345);
        chk("held_remainder", dif.remainder, 32'h0000_0678);
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);

        // Cancel in DIV_ZERO
        @(posedge clock); #1;
        dif.start = 1'b1; dif.operand_a = 32'd9; dif.operand_b = 32'd0;
        @(posedge clock); #1;
        dif.start = 1'b0; dif.cancel = 1'b1;
        @(posedge clock); #1;
        dif.cancel = 1'b0;
        @(negedge clock);
        chk("stall_after_dz_cancel", W'(dif.stall), 32'd0);

        // Start with cancel in IDLE is ignored
        @(posedge clock); #1;
        dif.start = 1'b1; dif.cancel = 1'b1; dif.operand_a = 32'd50; dif.operand_b = 32'd5;
        @(negedge clock);
        chk("stall_start_cancel", W'(dif.stall), 32'd0);
        @(posedge clock); #1;
        dif.start = 1'b0; dif.cancel = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("ignored_quotient", dif.quotient, 32'd14);

        // Asynchronous reset at cycle 20 of a divide
        @(posedge clock); #1;
        dif.start = 1'b1; dif.operand_a = 32'd100; dif.operand_b = 32'd7;
        c0 = cyc;
        @(posedge clock); #1;
        dif.start = 1'b0;
        while (cyc < c0 + 20) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("async_quotient", dif.quotient, 32'd0);
        chk("async_remainder", dif.remainder, 32'd0);
        chk("async_stall", W'(dif.stall), 32'd0);
        chk("async_ready", W'(dif.ready), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (40) @(posedge clock);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);

        repeat (3) @(posedge clock);
        chk("scoreboard_empty", W'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
